// File: rtl/roi_host_pkg.sv
// roi_host_pkg -- shared types and defaults for the ROI shift-chain host.
//   state_e   : transaction sequencer states
//   DEF_*     : default chain widths and receive latency
//   ERR_CNT_W : width of the saturating mismatch counter (compare build)
package roi_host_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      STB1   = 3'd2,
      REFILL = 3'd3,
      STB2   = 3'd4,
      READ   = 3'd5,
      DONE   = 3'd6
   } state_e;

   localparam int DEF_DIN_N  = 256;
   localparam int DEF_DOUT_N = 256;
   localparam int DEF_RX_LAT = 0;
   localparam int ERR_CNT_W  = 16;

endpackage

// File: rtl/roi_host_delay.sv
// roi_host_delay -- LAT-deep flop pipe on the harness serial output.
//   clk, rst_n : clock, asynchronous active-low reset (pipe clears to 0)
//   din        : raw harness do
//   dout       : din delayed by LAT cycles; LAT=0 is a plain wire
module roi_host_delay #(
   parameter int LAT = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   generate
      if (LAT == 0) begin : g_wire
         // Clock and reset are not needed without stages; fold them away.
         logic unused_s;
         assign unused_s = clk ^ rst_n;
         assign dout     = din;
      end else begin : g_pipe
         logic [LAT-1:0] pipe_r;

         // Delay line: stage 0 takes din, each stage feeds the next
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pipe_r <= {LAT{1'b0}};
            end else begin
               pipe_r[0] <= din;
               for (int i = 1; i < LAT; i++) begin
                  pipe_r[i] <= pipe_r[i-1];
               end
            end
         end

         assign dout = pipe_r[LAT-1];
      end
   endgenerate

endmodule

// File: rtl/roi_shift_host.sv
// roi_shift_host -- host driver for the fuzzer serial harness.
// One transaction: shift tx_vec in MSB first, strobe (stale capture),
// shift tx_vec in again, strobe (real capture), shift DOUT_N bits out
// into rx_vec, then pulse done.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request; accepted in IDLE or DONE only
//   tx_vec     : vector to load, copied at accept
//   busy       : transaction in progress
//   done       : one-cycle pulse, rx_vec valid from this cycle
//   rx_vec     : captured ROI dout, held until next done
//   di, stb    : serial data and load/capture strobe to harness
//   do_in      : harness serial output
// Optional feature macro ROI_HOST_CMP_EN adds exp_vec (sampled at accept),
// mismatch (held with rx_vec) and err_cnt (saturating count of mismatches).
module roi_shift_host
   import roi_host_pkg::*;
#(
   parameter int DIN_N  = DEF_DIN_N,
   parameter int DOUT_N = DEF_DOUT_N,
   parameter int RX_LAT = DEF_RX_LAT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [DIN_N-1:0]     tx_vec,
`ifdef ROI_HOST_CMP_EN
   input  logic [DOUT_N-1:0]    exp_vec,
   output logic                 mismatch,
   output logic [ERR_CNT_W-1:0] err_cnt,
`endif
   output logic                 busy,
   output logic                 done,
   output logic [DOUT_N-1:0]    rx_vec,
   output logic                 di,
   output logic                 stb,
   input  logic                 do_in
);

   localparam int RD_N    = DOUT_N + RX_LAT;
   localparam int CNT_MAX = (DIN_N > RD_N) ? DIN_N : RD_N;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = $clog2(DIN_N);

   state_e              state_r, state_n;
   logic [CNT_W-1:0]    cnt_r, cnt_n;
   logic [DIN_N-1:0]    tx_q_r, tx_n;
   logic [DOUT_N-1:0]   sh_r, sh_n;
   logic [DOUT_N-1:0]   rx_vec_r, rx_n;
   logic                busy_r, busy_n;
   logic                done_r, done_n;
   logic                di_r, di_n;
   logic                stb_r, stb_n;
   logic                accept_s;
   logic                do_s;
   logic [IDX_W-1:0]    idx_s;

   roi_host_delay #(.LAT(RX_LAT)) u_delay (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (do_in),
      .dout (do_s)
   );

   // Sequencer next state, counter, datapath and next-cycle output decode
   always_comb begin
      state_n  = state_r;
      cnt_n    = cnt_r;
      tx_n     = tx_q_r;
      sh_n     = sh_r;
      accept_s = 1'b0;
      case (state_r)
         IDLE, DONE: begin
            if (start) begin
               accept_s = 1'b1;
               state_n  = LOAD;
               cnt_n    = {CNT_W{1'b0}};
               tx_n     = tx_vec;
               sh_n     = {DOUT_N{1'b0}};
            end else begin
               state_n  = IDLE;
               cnt_n    = {CNT_W{1'b0}};
            end
         end
         LOAD, REFILL: begin
            if (cnt_r == CNT_W'(DIN_N - 1)) begin
               state_n = (state_r == LOAD) ? STB1 : STB2;
               cnt_n   = {CNT_W{1'b0}};
            end else begin
               cnt_n   = cnt_r + CNT_W'(1);
            end
         end
         STB1: begin
            state_n = REFILL;
            cnt_n   = {CNT_W{1'b0}};
         end
         STB2: begin
            state_n = READ;
            cnt_n   = {CNT_W{1'b0}};
         end
         READ: begin
            // The first RX_LAT samples predate the captured data.
            if (cnt_r >= CNT_W'(RX_LAT)) begin
               sh_n = {sh_r[DOUT_N-2:0], do_s};
            end else begin
               sh_n = sh_r;
            end
            if (cnt_r == CNT_W'(RD_N - 1)) begin
               state_n = DONE;
               cnt_n   = {CNT_W{1'b0}};
            end else begin
               cnt_n   = cnt_r + CNT_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = {CNT_W{1'b0}};
         end
      endcase

      // Outputs are registered from the next state so they line up with it.
      idx_s  = IDX_W'(DIN_N - 1) - IDX_W'(cnt_n);
      busy_n = (state_n != IDLE) && (state_n != DONE);
      done_n = (state_n == DONE);
      stb_n  = (state_n == STB1) || (state_n == STB2);
      if ((state_n == LOAD) || (state_n == REFILL)) begin
         di_n = tx_n[idx_s];
      end else begin
         di_n = 1'b0;
      end
      if (state_n == DONE) begin
         rx_n = sh_n;
      end else begin
         rx_n = rx_vec_r;
      end
   end

   // Sequencer state, counter, vector copies and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         cnt_r    <= {CNT_W{1'b0}};
         tx_q_r   <= {DIN_N{1'b0}};
         sh_r     <= {DOUT_N{1'b0}};
         rx_vec_r <= {DOUT_N{1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         di_r     <= 1'b0;
         stb_r    <= 1'b0;
      end else begin
         state_r  <= state_n;
         cnt_r    <= cnt_n;
         tx_q_r   <= tx_n;
         sh_r     <= sh_n;
         rx_vec_r <= rx_n;
         busy_r   <= busy_n;
         done_r   <= done_n;
         di_r     <= di_n;
         stb_r    <= stb_n;
      end
   end

   assign busy   = busy_r;
   assign done   = done_r;
   assign di     = di_r;
   assign stb    = stb_r;
   assign rx_vec = rx_vec_r;

`ifdef ROI_HOST_CMP_EN
   logic [DOUT_N-1:0]    exp_q_r;
   logic                 mismatch_r;
   logic [ERR_CNT_W-1:0] err_cnt_r;

   // Expected-vector copy, result compare and saturating error count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q_r    <= {DOUT_N{1'b0}};
         mismatch_r <= 1'b0;
         err_cnt_r  <= {ERR_CNT_W{1'b0}};
      end else begin
         if (accept_s) begin
            exp_q_r <= exp_vec;
         end
         if (state_n == DONE) begin
            mismatch_r <= (sh_n != exp_q_r);
            if ((sh_n != exp_q_r) && (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
               err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
            end
         end
      end
   end

   assign mismatch = mismatch_r;
   assign err_cnt  = err_cnt_r;
`else
   logic unused_accept_s;
   assign unused_accept_s = accept_s;
`endif

endmodule
